// File: rtl/sgd_result_packer_pkg.sv
// Shared types and helpers for the SGD result packer: FSM states, output word
// geometry and the byte-length arithmetic used at job accept.
package sgd_pack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    PACK,
    FLUSH,
    DONE
  } pack_state_e;

  localparam int OUT_W     = 512;
  localparam int OUT_BYTES = 64;

  // 33-bit sum so a beat count near 2^32 cannot wrap before the divide.
  function automatic logic [32:0] ceil_div_words(input logic [31:0] num_beats,
                                                 input int unsigned ratio);
    logic [32:0] sum;
    sum = {1'b0, num_beats} + 33'(ratio) - 33'd1;
    return sum / 33'(ratio);
  endfunction

  function automatic logic [31:0] words_to_bytes(input logic [32:0] words);
    if (words > 33'h3FF_FFFF) begin
      return 32'hFFFF_FFC0;
    end
    return {words[25:0], 6'b0};
  endfunction

endpackage

// File: rtl/sgd_result_packer_accum.sv
// Lane accumulator: collects IN_W beats into a 512-bit word and hands it out
// with a one-cycle strobe; lanes are zeroed whenever a word leaves.
module pack_lane_accum
  import sgd_pack_pkg::*;
#(
  parameter  int IN_W  = 256,
  localparam int RATIO = OUT_W / IN_W,
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [IN_W-1:0]  wr_data_i,
  input  logic             flush_i,
  output logic [IDX_W-1:0] lane_idx_o,
  output logic             word_full_o,
  output logic [OUT_W-1:0] word_o
);

  logic [OUT_W-1:0] lanes_q, lanes_d, word_q, word_d, merged;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             full_q, full_d;
  logic             wrap;

  assign wrap = (idx_q == IDX_W'(RATIO - 1));

  always_comb begin
    merged = lanes_q;
    for (int i = 0; i < RATIO; i++) begin
      if (IDX_W'(i) == idx_q) begin
        merged[i*IN_W +: IN_W] = wr_data_i;
      end
    end
  end

  // A completed word is copied out and the lanes cleared in the same edge,
  // so a new beat can land in lane 0 while the previous word is pushed.
  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    word_d  = word_q;
    full_d  = 1'b0;
    if (clear_i) begin
      lanes_d = '0;
      idx_d   = '0;
    end else if (flush_i) begin
      word_d  = lanes_q;
      full_d  = 1'b1;
      lanes_d = '0;
      idx_d   = '0;
    end else if (wr_en_i) begin
      if (wrap) begin
        word_d  = merged;
        full_d  = 1'b1;
        lanes_d = '0;
        idx_d   = '0;
      end else begin
        lanes_d = merged;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lanes_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      full_q  <= full_d;
    end
  end

  assign lane_idx_o  = idx_q;
  assign word_full_o = full_q;
  assign word_o      = word_q;

endmodule

// File: rtl/sgd_result_packer.sv
// Packs IN_W update beats into 512-bit send-back words and sequences one job.
// Optional per-job statistics ports are enabled with SGD_PACKER_STATS_EN.
module sgd_result_packer
  import sgd_pack_pkg::*;
#(
  parameter int IN_W  = 256,
  parameter int CNT_W = 32
) (
  input  logic             hbm_clk,
  input  logic             hbm_aresetn,
  input  logic             job_start,
  input  logic [63:0]      job_addr,
  input  logic [31:0]      job_num_beats,
  output logic             job_busy,
  output logic             job_done,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             start,
  output logic [63:0]      addr_x,
  output logic [31:0]      data_length,
  output logic [OUT_W-1:0] back_data,
  output logic             back_valid,
  input  logic             almost_full
`ifdef SGD_PACKER_STATS_EN
  ,
  output logic [31:0]      stat_words,
  output logic [31:0]      stat_stall
`endif
);

  localparam int RATIO = OUT_W / IN_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  pack_state_e      state_q, state_d;
  logic [63:0]      addr_q;
  logic [31:0]      len_q;
  logic [CNT_W-1:0] num_q, cnt_q;
  logic             done_q;
  logic             accept, hs, last_beat, lane_wrap, flush, done_pulse;
  logic [IDX_W-1:0] lane_idx;
  logic             word_full;
  logic [OUT_W-1:0] word;

  assign accept    = (state_q == IDLE) && job_start;
  assign hs        = in_valid && in_ready;
  assign last_beat = hs && ((cnt_q + CNT_W'(1)) == num_q);
  assign lane_wrap = (lane_idx == IDX_W'(RATIO - 1));

  pack_lane_accum #(.IN_W(IN_W)) u_accum (
    .clk_i       (hbm_clk),
    .rst_ni      (hbm_aresetn),
    .clear_i     (accept),
    .wr_en_i     (hs),
    .wr_data_i   (in_data),
    .flush_i     (flush),
    .lane_idx_o  (lane_idx),
    .word_full_o (word_full),
    .word_o      (word)
  );

  always_ff @(posedge hbm_clk) begin
    if (!hbm_aresetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_pulse;
      if (accept) begin
        addr_q <= job_addr;
        len_q  <= words_to_bytes(ceil_div_words(job_num_beats, RATIO));
        num_q  <= CNT_W'(job_num_beats);
        cnt_q  <= '0;
      end else if (hs) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // A final beat that also fills the top lane skips FLUSH: that word is already out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (job_start) state_d = ISSUE;
      ISSUE:   state_d = (num_q == '0) ? DONE : PACK;
      PACK:    if (last_beat) state_d = lane_wrap ? DONE : FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start      = (state_q == ISSUE);
    job_busy   = (state_q != IDLE);
    in_ready   = (state_q == PACK) && !almost_full && (cnt_q < num_q);
    flush      = (state_q == FLUSH);
    done_pulse = (state_q == DONE);
  end

  assign job_done    = done_q;
  assign addr_x      = addr_q;
  assign data_length = len_q;
  assign back_data   = word;
  assign back_valid  = word_full;

`ifdef SGD_PACKER_STATS_EN
  logic [31:0] words_q, stall_q;

  always_ff @(posedge hbm_clk) begin
    if (!hbm_aresetn) begin
      words_q <= '0;
      stall_q <= '0;
    end else if (accept) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (word_full && (words_q != '1)) words_q <= words_q + 32'd1;
      if ((state_q == PACK) && in_valid && almost_full && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: doc/sgd_result_packer.md
Name: sgd_result_packer

Overview:
- Upstream feeder of the HBM send-back stage. It gathers narrow update beats from the SGD compute pipeline and packs them into 512-bit words.
- It drives the send-back push interface (back_data/back_valid), which has no ready signal. Backpressure comes only from the send-back stage's registered almost_full.
- Per job it also generates the send-back start pulse, the host address and a byte length rounded up to a whole number of 64 B beats.

Parameters:
IN_W, 256, input beat width in bits; must divide 512 (legal values 32, 64, 128, 256, 512)
RATIO, 512/IN_W, derived localparam: input beats per output word
CNT_W, 32, width of the beat and byte counters

Ports:
hbm_clk  in  1  clock
hbm_aresetn  in  1  synchronous active-low reset
job_start  in  1  one-cycle pulse; accepted only in IDLE
job_addr  in  64  host byte address of the result buffer
job_num_beats  in  32  number of IN_W input beats in the job
job_busy  out  1  high from job accept until DONE exits
job_done  out  1  one-cycle pulse when the last word has been pushed
in_valid  in  1  input beat valid
in_data  in  IN_W  input beat; lane 0 goes to the LSBs
in_ready  out  1  high when an input beat is accepted
start  out  1  one-cycle pulse to the send-back stage
addr_x  out  64  registered job_addr
data_length  out  32  ceil(job_num_beats/RATIO)*64 bytes
back_data  out  512  packed word
back_valid  out  1  push strobe
almost_full  in  1  registered prog_full from the send-back stage

Behaviour:
- Reset values: all outputs 0, state IDLE, accumulator cleared, counters 0. Reset mid-job aborts the job; no partial word is emitted.
- States and transitions:
  - IDLE: on job_start, latch job_addr and job_num_beats, compute out_words = ceil(num_beats/RATIO), go to ISSUE. job_start in any other state is ignored.
  - ISSUE: start=1 for exactly one cycle, with addr_x and data_length stable from this cycle until the next job. Next state is PACK, or DONE if num_beats==0 (start is still pulsed, data_length=0).
  - PACK:
    - in_ready = ~almost_full & (in_cnt < num_beats).
    - Each handshake writes in_data into lane slot lane_idx, then increments lane_idx (wraps at RATIO) and in_cnt.
    - When lane_idx wraps, the next cycle pushes back_valid=1 with the full word (1-cycle latency from the last lane accepted).
    - When in_cnt reaches num_beats: go to FLUSH if lane_idx!=0, else DONE.
  - FLUSH: push the partial word with the unfilled upper lanes zeroed, then go to DONE. almost_full is ignored here (single word; covered by the margin below).
  - DONE: job_done=1 for one cycle, then IDLE.
- back_valid is never gated after a word is formed. Worst-case words pushed after almost_full rises is 2 (slack budget); the send-back FIFO prog_full threshold must leave ≥4 free entries.
- Accumulator lanes are cleared after every push, so padding is always zeros.
- Arithmetic: data_length = out_words<<6, computed in 32 bits. num_beats ≥ 2^26*RATIO saturates data_length at 32'hFFFF_FFC0 and flags nothing (caller contract).
- A word-completing handshake and an almost_full rise in the same cycle: the word still pushes, and in_ready drops the next cycle.
- The lane-index wrap and the final beat in the same cycle: push the word, then go straight to DONE with no FLUSH.

Optional Feature:
- Macro: SGD_PACKER_STATS_EN.
- When defined:
  - Adds outputs stat_words[31:0] (words pushed) and stat_stall[31:0] (cycles in PACK with in_valid=1 and almost_full=1).
  - Both counters clear on job accept and saturate at all-ones.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package sgd_pack_pkg:
  - state enum (IDLE, ISSUE, PACK, FLUSH, DONE)
  - OUT_W=512, OUT_BYTES=64
  - function ceil_div_words(num_beats, ratio)
- Sub-module pack_lane_accum: RATIO-slot shift/select register with lane_idx, word_full and a clear input. Its parameter is IN_W; the top-level FSM instantiates it once.

Test Plan:
- IN_W=256, job_num_beats=8, addr=0x1000, in_valid always 1 -> start pulse with data_length=256; 4 back_valid pushes; word k = {in[2k+1],in[2k]}; job_done 1 cycle after the 4th push.
- job_num_beats=5 -> data_length=192; 3 pushes; 3rd word upper 256 bits = 0; FLUSH visited.
- almost_full held high for 10 cycles mid-job with num_beats=16 -> in_ready=0 throughout; ≤1 word pushed after the rise; all 8 words correct after release.
- job_num_beats=0 -> start pulse with data_length=0; no back_valid; job_done.
- Reset asserted after 3 of 8 beats -> all outputs 0 next cycle; a new job of 2 beats then completes with 1 correct word.
- SGD_PACKER_STATS_EN defined, the almost_full case above -> stat_words=8, stat_stall=10.
